pad_cfg_ctrl: RTL and testbench

Core-side pad configuration controller that generates the per-pad control levels (OE, CS, SL, IE, PU, PD) consumed by the pad ring. It sits inside `chip_core` and drives the `bidir_*` and `input_pu/pd` outputs. Configuration is written into a shadow bank over a valid/ready port, then committed to the active bank. The commit is applied in groups across consecutive cycles, which limits simultaneous switching on the 24 mA bidir drivers.

---
 rtl/pad_cfg_ctrl.sv | 154 +++++++++++++++
 tb/tb_pad_cfg_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pad_cfg_ctrl.sv
// Pad configuration controller: shadow bank written over valid/ready, committed to the
// active bank in GROUP_SIZE-pad slices per cycle. Optional readback: PAD_CFG_READBACK_EN.
module pad_cfg_ctrl #(
  parameter int NUM_BIDIR_PADS = 40,
  parameter int NUM_INPUT_PADS = 13,
  parameter int GROUP_SIZE     = 8,
  localparam int N             = NUM_BIDIR_PADS + NUM_INPUT_PADS,
  localparam int AW            = $clog2(N)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [AW-1:0]             wr_addr,
  input  logic [5:0]                wr_data,
  output logic                      wr_err,
  input  logic                      commit,
  output logic                      busy,
  output logic                      done,
`ifdef PAD_CFG_READBACK_EN
  input  logic [AW-1:0]             rd_addr,
  output logic [5:0]                rd_data,
`endif
  output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
  output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
  output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
  output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pd,
  output logic [NUM_INPUT_PADS-1:0] input_pu,
  output logic [NUM_INPUT_PADS-1:0] input_pd
);

  localparam int G  = (N + GROUP_SIZE - 1) / GROUP_SIZE;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam logic [5:0] RST_BIDIR = 6'b001000;

  typedef enum logic {S_IDLE, S_APPLY} state_t;

  state_t          r_state, w_state_nxt;
  logic [GW-1:0]   r_grp, w_grp_nxt;
  logic            r_pend, w_pend_nxt;
  logic            r_done, w_done_nxt;
  logic            r_wr_err;
  logic            w_wr_acc, w_wr_inrange, w_apply;
  logic [5:0]      r_shadow [N];
  logic [5:0]      r_active [N];

  assign w_wr_acc     = wr_valid && (r_state == S_IDLE);
  assign w_wr_inrange = (int'(wr_addr) < N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_grp    <= '0;
      r_pend   <= 1'b0;
      r_done   <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_grp    <= w_grp_nxt;
      r_pend   <= w_pend_nxt;
      r_done   <= w_done_nxt;
      r_wr_err <= w_wr_acc && !w_wr_inrange;
    end
  end

  // A commit seen on the last group's edge chains straight into the next pass.
  always_comb begin
    w_state_nxt = r_state;
    w_grp_nxt   = r_grp;
    w_pend_nxt  = r_pend;
    w_done_nxt  = 1'b0;
    w_apply     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (commit) begin
          w_state_nxt = S_APPLY;
          w_grp_nxt   = '0;
          w_pend_nxt  = 1'b0;
        end
      end
      S_APPLY: begin
        w_apply = 1'b1;
        if (commit) w_pend_nxt = 1'b1;
        if (r_grp == GW'(G - 1)) begin
          w_done_nxt = 1'b1;
          w_grp_nxt  = '0;
          w_pend_nxt = 1'b0;
          if (!(r_pend || commit)) w_state_nxt = S_IDLE;
        end else begin
          w_grp_nxt = r_grp + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Input pads keep only pu/pd; their low bits stay zero so readback needs no masking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_shadow[i] <= (i < NUM_BIDIR_PADS) ? RST_BIDIR : 6'b0;
        r_active[i] <= (i < NUM_BIDIR_PADS) ? RST_BIDIR : 6'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_wr_acc && (int'(wr_addr) == i))
          r_shadow[i] <= (i < NUM_BIDIR_PADS) ? wr_data : {wr_data[5:4], 4'b0};
        if (w_apply && (int'(r_grp) == (i / GROUP_SIZE)))
          r_active[i] <= r_shadow[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
      bidir_oe[i] = r_active[i][0];
      bidir_cs[i] = r_active[i][1];
      bidir_sl[i] = r_active[i][2];
      bidir_ie[i] = r_active[i][3];
      bidir_pu[i] = r_active[i][4];
      bidir_pd[i] = r_active[i][5];
    end
    for (int j = 0; j < NUM_INPUT_PADS; j++) begin
      input_pu[j] = r_active[NUM_BIDIR_PADS + j][4];
      input_pd[j] = r_active[NUM_BIDIR_PADS + j][5];
    end
  end

`ifdef PAD_CFG_READBACK_EN
  logic [5:0] r_rd_data;
  logic [5:0] w_rd_mux;

  always_comb begin
    w_rd_mux = 6'b0;
    for (int i = 0; i < N; i++)
      if (int'(rd_addr) == i) w_rd_mux = r_active[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_data <= 6'b0;
    else        r_rd_data <= w_rd_mux;
  end

  assign rd_data = r_rd_data;
`endif

  assign wr_ready = (r_state == S_IDLE);
  assign busy     = (r_state == S_APPLY);
  assign done     = r_done;
  assign wr_err   = r_wr_err;

endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// Directed bench for pad_cfg_ctrl: reset, shadow isolation, grouped apply timing,
// chained commits, input-pad masking, bad address and mid-pass reset.
module tb_pad_cfg_ctrl;
  localparam int NB = 40;
  localparam int NI = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [5:0]    wr_addr = '0;
  logic [5:0]    wr_data = '0;
  logic          wr_err;
  logic          commit = 1'b0;
  logic          busy, done;
  logic [NB-1:0] bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;
  logic [NI-1:0] input_pu, input_pd;
`ifdef PAD_CFG_READBACK_EN
  logic [5:0]    rd_addr = '0;
  logic [5:0]    rd_data;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  pad_cfg_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_err(wr_err), .commit(commit), .busy(busy), .done(done),
`ifdef PAD_CFG_READBACK_EN
    .rd_addr(rd_addr), .rd_data(rd_data),
`endif
    .bidir_oe(bidir_oe), .bidir_cs(bidir_cs), .bidir_sl(bidir_sl),
    .bidir_ie(bidir_ie), .bidir_pu(bidir_pu), .bidir_pd(bidir_pd),
    .input_pu(input_pu), .input_pd(input_pd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NB-1:0] lo_mask(input int n);
    logic [NB-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) if (i < n) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [6*NB+2*NI-1:0] snap();
    return {bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd, input_pu, input_pd};
  endfunction

  // Called at a falling edge; the write lands on the next rising edge.
  task automatic wr(input logic [5:0] a, input logic [5:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  logic [6*NB+2*NI-1:0] prev, cur;
  logic [NB-1:0] exp_oe;

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_ie", bidir_ie, {NB{1'b1}});
    check("rst_oe", bidir_oe, '0);
    check("rst_ipu", input_pu, '0);
    check("rst_ipd", input_pd, '0);
    check("rst_ready", wr_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", wr_err, 1'b0);

    // Shadow write stays invisible without a commit
    wr(6'd5, 6'h09);
    repeat (10) @(negedge clk);
    check("nocommit_oe5", bidir_oe[5], 1'b0);
    check("nocommit_ie", bidir_ie, {NB{1'b1}});
`ifdef PAD_CFG_READBACK_EN
    rd_addr = 6'd5;
    @(negedge clk);
    check("rb_addr5", rd_data, 6'h08);
`endif

    // Grouped apply: oe=1 on every bidir pad
    for (int i = 0; i < NB; i++) wr(6'(i), 6'h09);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    prev = snap();
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) @(negedge clk);
      exp_oe = lo_mask(8 * k);
      check("grp_oe", bidir_oe, exp_oe);
      check("grp_busy", busy, (k < 7));
      check("grp_done", done, (k == 7));
      if (k == 0) check("grp_ready", wr_ready, 1'b0);
      cur = snap();
      check("grp_sso", ($countones(cur ^ prev) <= 8), 1'b1);
      prev = cur;
    end
    check("grp_ie", bidir_ie, {NB{1'b1}});

    // Write+commit in one cycle, second commit at E+3
    wr_valid = 1'b1;
    wr_addr  = 6'd40;
    wr_data  = 6'h3F;
    commit   = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    commit   = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) @(negedge clk);
      check("chain_busy", busy, (k < 14));
      check("chain_done", done, (k == 7 || k == 14));
      check("chain_ready", wr_ready, (k >= 14));
      check("chain_ipu", input_pu, (k >= 6) ? 13'h1 : 13'h0);
      check("chain_ipd", input_pd, (k >= 6) ? 13'h1 : 13'h0);
      if (k == 2) commit = 1'b1;
      if (k == 3) commit = 1'b0;
    end

    // Bad address, input-pad masking, field mapping, no-change pass length
    wr(6'd53, 6'h3F);
    check("bad_err", wr_err, 1'b1);
    @(negedge clk);
    check("bad_err_clr", wr_err, 1'b0);
    wr(6'd41, 6'h0F);
    check("good_err", wr_err, 1'b0);
    wr(6'd39, 6'h3F);
    wr(6'd1, 6'h04);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) @(negedge clk);
      check("pass_busy", busy, (k < 7));
      check("pass_done", done, (k == 7));
    end
    check("map_oe", bidir_oe, {NB{1'b1}} & ~(40'h1 << 1));
    check("map_ie", bidir_ie, {NB{1'b1}} & ~(40'h1 << 1));
    check("map_sl", bidir_sl, (40'h1 << 39) | (40'h1 << 1));
    check("map_cs", bidir_cs, 40'h1 << 39);
    check("map_pu", bidir_pu, 40'h1 << 39);
    check("map_pd", bidir_pd, 40'h1 << 39);
    check("mask_ipu", input_pu, 13'h1);
    check("mask_ipd", input_pd, 13'h1);
`ifdef PAD_CFG_READBACK_EN
    rd_addr = 6'd39;
    @(negedge clk);
    check("rb_39", rd_data, 6'h3F);
    rd_addr = 6'd40;
    @(negedge clk);
    check("rb_40", rd_data, 6'h30);
    rd_addr = 6'd60;
    @(negedge clk);
    check("rb_oor", rd_data, 6'h00);
`endif

    // Reset mid-pass
    for (int i = 0; i < NB; i++) wr(6'(i), 6'h00);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_oe", bidir_oe, '0);
    check("mid_ie", bidir_ie, {NB{1'b1}});
    check("mid_sl", bidir_sl, '0);
    check("mid_ipu", input_pu, '0);
    check("mid_busy", busy, 1'b0);
    check("mid_ready", wr_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("mid_nodone", done, 1'b0);
      check("mid_idle", busy, 1'b0);
    end
    check("mid_oe_after", bidir_oe, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
